// File: rtl/axi4_mm_bram_responder_if.sv
`default_nettype none
// ============================================================================
// Module  : axi4_mm_bram_responder_if
// Brief   : AXI4 memory-mapped bus bundle between the debugger master and the
//           on-chip RAM responder.
// Revision: 1.0
// ============================================================================
interface axi4_mm_bram_responder_if #(
    parameter int ID_W = 4,
    parameter int DW   = 512
);
    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awvalid;
    logic            awready;

    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arvalid;
    logic            arready;

    logic [ID_W-1:0] rid;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface
`default_nettype wire

// File: rtl/axi4_mm_bram_responder.sv
`default_nettype none
// ============================================================================
// Module  : axi4_mm_bram_responder
// Brief   : AXI4 slave backed by a byte-enable simple dual-port RAM; answers
//           INCR/FIXED bursts with independent write and read engines.
// Revision: 1.0
// ============================================================================
module axi4_mm_bram_responder #(
    parameter int C_S_AXI_ID_WIDTH   = 4,
    parameter int AXI4_MM_DATA_WIDTH = 512,
    parameter int MEM_ADDR_BITS      = 10
) (
    input  wire logic               sys_clk,
    input  wire logic               sys_rst,
    axi4_mm_bram_responder_if.slave s_axi
);
    localparam int         c_strb_w      = AXI4_MM_DATA_WIDTH / 8;
    localparam int         c_addr_lsb    = $clog2(c_strb_w);
    localparam int         c_depth       = 1 << MEM_ADDR_BITS;
    localparam logic [2:0] c_size        = 3'(c_addr_lsb);
    localparam logic [1:0] c_burst_fixed = 2'b00;
    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_slverr = 2'b10;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    logic [AXI4_MM_DATA_WIDTH-1:0] r_mem [0:c_depth-1];
    logic [AXI4_MM_DATA_WIDTH-1:0] r_ram_q;

    w_state_t                    r_wstate;
    logic                        r_awready, r_wready, r_bvalid;
    logic [1:0]                  r_bresp;
    logic [C_S_AXI_ID_WIDTH-1:0] r_bid;
    logic [MEM_ADDR_BITS-1:0]    r_widx;
    logic [7:0]                  r_wcnt;
    logic                        r_wfixed, r_werr, r_wlast_err;

    r_state_t                    r_rstate;
    logic                        r_arready, r_rvalid, r_rlast;
    logic [1:0]                  r_rresp;
    logic [C_S_AXI_ID_WIDTH-1:0] r_rid;
    logic [MEM_ADDR_BITS-1:0]    r_ridx;
    logic [7:0]                  r_rcnt;
    logic                        r_rfixed, r_rerr;

    logic                     w_aw_err, w_ar_err, w_wbeat, w_wfinal, w_wlast_bad, w_we, w_rbeat;
    logic [MEM_ADDR_BITS-1:0] w_aw_idx, w_ar_idx, w_ridx_next, w_raddr;
    logic                     w_unused_addr_bits;

    // Only the word-index slice of the addresses matters; the rest aliases.
    assign w_unused_addr_bits = ^{s_axi.awaddr, s_axi.araddr};

    assign w_aw_err    = (s_axi.awsize != c_size) || s_axi.awburst[1];
    assign w_ar_err    = (s_axi.arsize != c_size) || s_axi.arburst[1];
    assign w_aw_idx    = s_axi.awaddr[c_addr_lsb +: MEM_ADDR_BITS];
    assign w_ar_idx    = s_axi.araddr[c_addr_lsb +: MEM_ADDR_BITS];

    assign w_wbeat     = (r_wstate == W_DATA) && s_axi.wvalid;
    assign w_wfinal    = (r_wcnt == 8'd0);
    assign w_wlast_bad = (s_axi.wlast != w_wfinal);
    assign w_we        = w_wbeat && !r_werr;

    assign w_rbeat     = r_rvalid && s_axi.rready;
    assign w_ridx_next = r_rfixed ? r_ridx : r_ridx + 1'b1;
    // Re-reading the current word while stalled keeps rdata stable.
    assign w_raddr     = (r_rstate == R_IDLE) ? w_ar_idx :
                         (w_rbeat ? w_ridx_next : r_ridx);

    // Both ports update on the same edge, so a same-word collision reads old data.
    always_ff @(posedge sys_clk) begin
        if (w_we) begin
            for (int b = 0; b < c_strb_w; b++) begin
                if (s_axi.wstrb[b]) begin
                    r_mem[r_widx][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
                end
            end
        end
        r_ram_q <= r_mem[w_raddr];
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_wstate    <= W_IDLE;
            r_awready   <= 1'b1;
            r_wready    <= 1'b0;
            r_bvalid    <= 1'b0;
            r_bresp     <= c_resp_okay;
            r_bid       <= '0;
            r_widx      <= '0;
            r_wcnt      <= 8'd0;
            r_wfixed    <= 1'b0;
            r_werr      <= 1'b0;
            r_wlast_err <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (r_awready && s_axi.awvalid) begin
                        r_bid       <= s_axi.awid;
                        r_widx      <= w_aw_idx;
                        r_wcnt      <= s_axi.awlen;
                        r_wfixed    <= (s_axi.awburst == c_burst_fixed);
                        r_werr      <= w_aw_err;
                        r_wlast_err <= 1'b0;
                        r_awready   <= 1'b0;
                        r_wready    <= 1'b1;
                        r_wstate    <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_wbeat) begin
                        if (w_wfinal) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= (r_werr || r_wlast_err || w_wlast_bad) ?
                                        c_resp_slverr : c_resp_okay;
                            r_wstate <= W_RESP;
                        end else begin
                            r_wcnt <= r_wcnt - 8'd1;
                            if (!r_wfixed) begin
                                r_widx <= r_widx + 1'b1;
                            end
                            if (w_wlast_bad) begin
                                r_wlast_err <= 1'b1;
                            end
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi.bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rresp   <= c_resp_okay;
            r_rid     <= '0;
            r_ridx    <= '0;
            r_rcnt    <= 8'd0;
            r_rfixed  <= 1'b0;
            r_rerr    <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (r_arready && s_axi.arvalid) begin
                        r_rid     <= s_axi.arid;
                        r_ridx    <= w_ar_idx;
                        r_rcnt    <= s_axi.arlen;
                        r_rfixed  <= (s_axi.arburst == c_burst_fixed);
                        r_rerr    <= w_ar_err;
                        r_rresp   <= w_ar_err ? c_resp_slverr : c_resp_okay;
                        r_rlast   <= (s_axi.arlen == 8'd0);
                        r_rvalid  <= 1'b1;
                        r_arready <= 1'b0;
                        r_rstate  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (w_rbeat) begin
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            r_rcnt  <= r_rcnt - 8'd1;
                            r_rlast <= (r_rcnt == 8'd1);
                            r_ridx  <= w_ridx_next;
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign s_axi.awready = r_awready;
    assign s_axi.wready  = r_wready;
    assign s_axi.bvalid  = r_bvalid;
    assign s_axi.bresp   = r_bresp;
    assign s_axi.bid     = r_bid;
    assign s_axi.arready = r_arready;
    assign s_axi.rvalid  = r_rvalid;
    assign s_axi.rlast   = r_rlast;
    assign s_axi.rresp   = r_rresp;
    assign s_axi.rid     = r_rid;
    // Errored reads and idle cycles present zero data.
    assign s_axi.rdata   = (r_rvalid && !r_rerr) ? r_ram_q : '0;
endmodule
`default_nettype wire

// File: tb/tb_axi4_mm_bram_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_axi4_mm_bram_responder
// Brief   : Directed self-checking bench for the AXI4 BRAM responder.
// Revision: 1.0
// ============================================================================
module tb_axi4_mm_bram_responder;
    localparam int DW    = 512;
    localparam int SW    = DW / 8;
    localparam int IDW   = 4;
    localparam int LIMIT = 200;
    localparam logic [1:0] INCR = 2'b01, FIXED = 2'b00, WRAP = 2'b10;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int   ncmp    = 0;
    int   nfail   = 0;

    logic [DW-1:0]  wd    [0:255];
    logic [DW-1:0]  rd    [0:255];
    logic [1:0]     rr    [0:255];
    logic           rl    [0:255];
    logic [IDW-1:0] rid_q [0:255];

    always #5 sys_clk = ~sys_clk;

    axi4_mm_bram_responder_if #(.ID_W(IDW), .DW(DW)) ifc ();

    axi4_mm_bram_responder #(
        .C_S_AXI_ID_WIDTH   (IDW),
        .AXI4_MM_DATA_WIDTH (DW),
        .MEM_ADDR_BITS      (10)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .s_axi   (ifc)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        ifc.awid = '0; ifc.awaddr = '0; ifc.awlen = '0; ifc.awsize = '0; ifc.awburst = '0; ifc.awvalid = 1'b0;
        ifc.wdata = '0; ifc.wstrb = '0; ifc.wlast = 1'b0; ifc.wvalid = 1'b0; ifc.bready = 1'b0;
        ifc.arid = '0; ifc.araddr = '0; ifc.arlen = '0; ifc.arsize = '0; ifc.arburst = '0; ifc.arvalid = 1'b0;
        ifc.rready = 1'b0;
    endtask

    // All driving happens on the falling edge; a valid seen with ready high
    // there completes on the next rising edge.
    task automatic aw_issue(input logic [IDW-1:0] id, input logic [31:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        ifc.awid = id; ifc.awaddr = addr; ifc.awlen = 8'(len); ifc.awsize = size; ifc.awburst = burst;
        ifc.awvalid = 1'b1;
        while (ifc.awready !== 1'b1 && n < LIMIT) begin @(negedge sys_clk); n++; end
        check("aw_handshake_timeout", DW'(n < LIMIT), DW'(1));
        @(negedge sys_clk);
        ifc.awvalid = 1'b0;
    endtask

    task automatic ar_issue(input logic [IDW-1:0] id, input logic [31:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        ifc.arid = id; ifc.araddr = addr; ifc.arlen = 8'(len); ifc.arsize = size; ifc.arburst = burst;
        ifc.arvalid = 1'b1;
        while (ifc.arready !== 1'b1 && n < LIMIT) begin @(negedge sys_clk); n++; end
        check("ar_handshake_timeout", DW'(n < LIMIT), DW'(1));
        @(negedge sys_clk);
        ifc.arvalid = 1'b0;
    endtask

    task automatic do_write(input logic [IDW-1:0] id, input logic [31:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [SW-1:0] strb,
                            input int last_at, output logic [1:0] bresp, output logic [IDW-1:0] bid);
        int n;
        aw_issue(id, addr, len, size, burst);
        for (int i = 0; i <= len; i++) begin
            ifc.wdata = wd[i]; ifc.wstrb = strb; ifc.wlast = (i == len) || (i == last_at);
            ifc.wvalid = 1'b1;
            n = 0;
            while (ifc.wready !== 1'b1 && n < LIMIT) begin @(negedge sys_clk); n++; end
            check("w_beat_timeout", DW'(n < LIMIT), DW'(1));
            @(negedge sys_clk);
        end
        ifc.wvalid = 1'b0; ifc.wlast = 1'b0; ifc.bready = 1'b1;
        n = 0;
        while (ifc.bvalid !== 1'b1 && n < LIMIT) begin @(negedge sys_clk); n++; end
        check("b_timeout", DW'(n < LIMIT), DW'(1));
        bresp = ifc.bresp; bid = ifc.bid;
        @(negedge sys_clk);
        ifc.bready = 1'b0;
    endtask

    task automatic do_read(input logic [IDW-1:0] id, input logic [31:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst, input bit toggle);
        int n = 0;
        int c = 0;
        bit held_v = 1'b0;
        logic [DW-1:0] held = '0;
        ar_issue(id, addr, len, size, burst);
        while (n <= len && c < 4 * LIMIT) begin
            ifc.rready = !toggle || (c % 2 == 0);
            if (ifc.rvalid === 1'b1) begin
                if (held_v) check("rdata_stable_while_stalled", ifc.rdata, held);
                if (ifc.rready) begin
                    rd[n] = ifc.rdata; rr[n] = ifc.rresp; rl[n] = ifc.rlast; rid_q[n] = ifc.rid;
                    n++; held_v = 1'b0;
                end else begin
                    held = ifc.rdata; held_v = 1'b1;
                end
            end
            @(negedge sys_clk);
            c++;
        end
        ifc.rready = 1'b0;
        check("r_burst_timeout", DW'(n), DW'(len + 1));
    endtask

    logic [1:0]     bresp;
    logic [IDW-1:0] bid;
    logic [DW-1:0]  pat_a, pat_b, exp_p;

    initial begin
        bus_idle();
        pat_a = {8{64'hDEAD_BEEF_0123_4567}};
        pat_b = {16{32'hC0DE_5A5A}};
        repeat (3) @(negedge sys_clk);
        check("rst_awready", DW'(ifc.awready), DW'(1));
        check("rst_arready", DW'(ifc.arready), DW'(1));
        check("rst_wready",  DW'(ifc.wready),  DW'(0));
        check("rst_bvalid",  DW'(ifc.bvalid),  DW'(0));
        check("rst_rvalid",  DW'(ifc.rvalid),  DW'(0));
        check("rst_rlast",   DW'(ifc.rlast),   DW'(0));
        check("rst_bresp_bid", DW'({ifc.bresp, ifc.bid}), DW'(0));
        check("rst_rresp_rid", DW'({ifc.rresp, ifc.rid}), DW'(0));
        check("rst_rdata",   ifc.rdata, DW'(0));
        sys_rst = 1'b0;
        @(negedge sys_clk);

        // Single-beat write and read-back
        wd[0] = pat_a;
        do_write(4'h3, 32'h40, 0, 3'd6, INCR, '1, 0, bresp, bid);
        check("single_bresp", DW'(bresp), DW'(OKAY));
        check("single_bid",   DW'(bid),   DW'(4'h3));
        do_read(4'h5, 32'h40, 0, 3'd6, INCR, 1'b0);
        check("single_rdata", rd[0], pat_a);
        check("single_rlast", DW'(rl[0]), DW'(1));
        check("single_rresp", DW'(rr[0]), DW'(OKAY));
        check("single_rid",   DW'(rid_q[0]), DW'(4'h5));
        check("arready_after_rlast", DW'(ifc.arready), DW'(1));

        // 16-beat INCR write, read back with rready toggling
        for (int i = 0; i < 16; i++) wd[i] = DW'(i);
        do_write(4'h1, 32'h0, 15, 3'd6, INCR, '1, 15, bresp, bid);
        check("incr16_bresp", DW'(bresp), DW'(OKAY));
        do_read(4'h2, 32'h0, 15, 3'd6, INCR, 1'b1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("incr16_rdata[%0d]", i), rd[i], DW'(i));
            check($sformatf("incr16_rlast[%0d]", i), DW'(rl[i]), DW'(i == 15));
            check($sformatf("incr16_rresp[%0d]", i), DW'(rr[i]), DW'(OKAY));
        end

        // FIXED burst keeps hitting the same word: last beat wins
        for (int i = 0; i < 4; i++) wd[i] = DW'(i + 1);
        do_write(4'h4, 32'h80, 3, 3'd6, FIXED, '1, 3, bresp, bid);
        check("fixed_bresp", DW'(bresp), DW'(OKAY));
        do_read(4'h4, 32'h80, 0, 3'd6, INCR, 1'b0);
        check("fixed_rdata", rd[0], DW'(4));

        // Partial strobe clears only byte 0
        wd[0] = '1;
        do_write(4'h6, 32'h100, 0, 3'd6, INCR, '1, 0, bresp, bid);
        wd[0] = '0;
        do_write(4'h6, 32'h100, 0, 3'd6, INCR, SW'(1), 0, bresp, bid);
        check("strobe_bresp", DW'(bresp), DW'(OKAY));
        exp_p = '1; exp_p[7:0] = 8'h00;
        do_read(4'h6, 32'h100, 0, 3'd6, INCR, 1'b0);
        check("strobe_rdata", rd[0], exp_p);

        // WRAP burst: all beats accepted, SLVERR, memory untouched
        for (int i = 0; i < 4; i++) wd[i] = '0;
        do_write(4'h7, 32'h100, 3, 3'd6, WRAP, '1, 3, bresp, bid);
        check("wrap_bresp", DW'(bresp), DW'(SLVERR));
        check("wrap_bid",   DW'(bid),   DW'(4'h7));
        do_read(4'h7, 32'h100, 0, 3'd6, INCR, 1'b0);
        check("wrap_ram_unchanged", rd[0], exp_p);

        // Narrow awsize
        do_write(4'h8, 32'h100, 0, 3'd3, INCR, '1, 0, bresp, bid);
        check("awsize_bresp", DW'(bresp), DW'(SLVERR));
        do_read(4'h8, 32'h100, 0, 3'd6, INCR, 1'b0);
        check("awsize_ram_unchanged", rd[0], exp_p);

        // Early wlast on beat 2 of 4
        do_write(4'h9, 32'h200, 3, 3'd6, INCR, '1, 1, bresp, bid);
        check("early_wlast_bresp", DW'(bresp), DW'(SLVERR));

        // Narrow arsize: two zero beats with SLVERR
        do_read(4'hA, 32'h100, 1, 3'd3, INCR, 1'b0);
        check("arsize_rdata0", rd[0], DW'(0));
        check("arsize_rdata1", rd[1], DW'(0));
        check("arsize_rresp0", DW'(rr[0]), DW'(SLVERR));
        check("arsize_rresp1", DW'(rr[1]), DW'(SLVERR));
        check("arsize_rlast",  DW'({rl[0], rl[1]}), DW'(2'b01));
        check("arsize_rid",    DW'(rid_q[1]), DW'(4'hA));

        // Reset during beat 5 of a 16-beat read
        begin
            int n = 0;
            int c = 0;
            ar_issue(4'hB, 32'h0, 15, 3'd6, INCR);
            ifc.rready = 1'b1;
            while (n < 4 && c < LIMIT) begin
                if (ifc.rvalid === 1'b1) n++;
                @(negedge sys_clk);
                c++;
            end
            check("rst_read_reach_beat5", DW'(n), DW'(4));
            sys_rst = 1'b1;
            #1;
            check("rst_read_rvalid",  DW'(ifc.rvalid),  DW'(0));
            check("rst_read_rlast",   DW'(ifc.rlast),   DW'(0));
            check("rst_read_arready", DW'(ifc.arready), DW'(1));
            check("rst_read_awready", DW'(ifc.awready), DW'(1));
            @(negedge sys_clk);
            ifc.rready = 1'b0;
            sys_rst = 1'b0;
            @(negedge sys_clk);
        end

        // Reset during W_DATA
        aw_issue(4'hC, 32'h0, 15, 3'd6, INCR);
        ifc.wdata = '0; ifc.wstrb = '0; ifc.wvalid = 1'b1;
        repeat (2) @(negedge sys_clk);
        check("rst_write_in_wdata", DW'(ifc.wready), DW'(1));
        sys_rst = 1'b1;
        #1;
        check("rst_write_wready",  DW'(ifc.wready),  DW'(0));
        check("rst_write_bvalid",  DW'(ifc.bvalid),  DW'(0));
        check("rst_write_awready", DW'(ifc.awready), DW'(1));
        check("rst_write_arready", DW'(ifc.arready), DW'(1));
        @(negedge sys_clk);
        ifc.wvalid = 1'b0;
        sys_rst = 1'b0;
        @(negedge sys_clk);

        // Fresh transaction after reset
        wd[0] = pat_b;
        do_write(4'hD, 32'h400, 0, 3'd6, INCR, '1, 0, bresp, bid);
        check("post_rst_bresp", DW'(bresp), DW'(OKAY));
        check("post_rst_bid",   DW'(bid),   DW'(4'hD));
        do_read(4'hE, 32'h400, 0, 3'd6, INCR, 1'b0);
        check("post_rst_rdata", rd[0], pat_b);
        check("post_rst_rresp", DW'(rr[0]), DW'(OKAY));
        check("post_rst_rid",   DW'(rid_q[0]), DW'(4'hE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
`default_nettype wire
